// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter sharing one multi-cycle ALU among NREQ
// requesters, with a single operation in flight at a time.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      per-requester request handshake (ready is a one-cycle pulse)
//   req_op/req_a/req_b       packed per-requester opcode (3b) and operands (8b each)
//   rsp_valid/rsp_ready      response handshake
//   rsp_id/rsp_result        owner index and ALU result of the response
//   alu_op_code/alu_a/alu_b  registered drive to the shared ALU
//   alu_result               ALU output, valid ALU_LAT edges after operand change
//   busy                     high whenever the FSM is not idle
//   grant_cnt                (ALU_ARB_STATS_EN only) 16b saturating grant counter per requester
//
// Build option: define ALU_ARB_STATS_EN to add the grant_cnt port and counters.

`ifdef ALU_ARB_STATS_EN
// Saturating per-requester grant counter.
module alu_arb_gcnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_inc,
  output logic [15:0] o_cnt
);
  always_ff @(posedge clk) begin
    if (rst)                          o_cnt <= '0;
    else if (i_inc && o_cnt != 16'hFFFF) o_cnt <= o_cnt + 16'd1;
  end
endmodule
`endif

module alu_arbiter #(
  parameter int NREQ    = 4,
  parameter int ALU_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [3*NREQ-1:0]   req_op,
  input  logic [8*NREQ-1:0]   req_a,
  input  logic [8*NREQ-1:0]   req_b,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [1:0]          rsp_id,
  output logic [15:0]         rsp_result,
  output logic [2:0]          alu_op_code,
  output logic [7:0]          alu_a,
  output logic [7:0]          alu_b,
  input  logic [15:0]         alu_result,
  output logic                busy
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [16*NREQ-1:0]  grant_cnt
`endif
);

  localparam int CW = (ALU_LAT < 1) ? 1 : $clog2(ALU_LAT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t          r_state;
  logic [1:0]      r_g;
  logic [1:0]      r_ptr;
  logic [CW-1:0]   r_cnt;

  // Unpack the flat request buses so the granted requester is a plain index.
  logic [NREQ-1:0][2:0] w_op;
  logic [NREQ-1:0][7:0] w_a;
  logic [NREQ-1:0][7:0] w_b;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign w_op[gi] = req_op[3*gi +: 3];
    assign w_a[gi]  = req_a[8*gi +: 8];
    assign w_b[gi]  = req_b[8*gi +: 8];
  end

  // Round-robin search: first valid requester at or after r_ptr, wrapping.
  logic [1:0] w_pick;
  logic       w_found;
  logic [2:0] w_sum;

  always_comb begin
    w_pick  = r_ptr;
    w_found = 1'b0;
    w_sum   = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_sum = {1'b0, r_ptr} + 3'(k);
      if (w_sum >= 3'(NREQ)) w_sum = w_sum - 3'(NREQ);
      if (!w_found && req_valid[w_sum[1:0]]) begin
        w_pick  = w_sum[1:0];
        w_found = 1'b1;
      end
    end
  end

  // Accept pulse only while ISSUE and the granted requester still holds valid.
  always_comb begin
    req_ready = '0;
    if (r_state == S_ISSUE && req_valid[r_g]) req_ready[r_g] = 1'b1;
  end

  assign rsp_valid = (r_state == S_RESP);
  assign busy      = (r_state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_g         <= '0;
      r_ptr       <= '0;
      r_cnt       <= '0;
      alu_op_code <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      rsp_id      <= '0;
      rsp_result  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|req_valid) begin
            r_g     <= w_pick;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (req_valid[r_g]) begin
            alu_op_code <= w_op[r_g];
            alu_a       <= w_a[r_g];
            alu_b       <= w_b[r_g];
            r_cnt       <= CW'(ALU_LAT);
            r_state     <= S_WAIT;
          end else begin
            // Requester withdrew before acceptance: drop the grant, keep ptr.
            r_state <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (r_cnt == '0) begin
            rsp_result <= alu_result;
            rsp_id     <= r_g;
            r_state    <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_ptr   <= (r_g == 2'(NREQ - 1)) ? 2'd0 : r_g + 2'd1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef ALU_ARB_STATS_EN
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_stats
    alu_arb_gcnt u_gcnt (
      .clk   (clk),
      .rst   (rst),
      .i_inc (req_ready[gi]),
      .o_cnt (grant_cnt[16*gi +: 16])
    );
  end
`else
  // No grant statistics in this build.
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: every accepted request pushes its expected
// {id, result}; every response handshake pops and compares.
module tb_alu_arbiter;
  localparam int NREQ = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [3*NREQ-1:0] req_op;
  logic [8*NREQ-1:0] req_a, req_b;
  logic              rsp_valid, rsp_ready;
  logic [1:0]        rsp_id;
  logic [15:0]       rsp_result;
  logic [2:0]        alu_op_code;
  logic [7:0]        alu_a, alu_b;
  logic [15:0]       alu_result = '0;
  logic              busy;
`ifdef ALU_ARB_STATS_EN
  logic [16*NREQ-1:0] grant_cnt;
`endif

  alu_arbiter #(.NREQ(NREQ), .ALU_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_result(rsp_result),
    .alu_op_code(alu_op_code), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .busy(busy)
`ifdef ALU_ARB_STATS_EN
    , .grant_cnt(grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int n_rsp = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // Reference ALU: add, sub, mul, else xor.
  function automatic logic [15:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0:    return {8'd0, a} + {8'd0, b};
      3'd1:    return {8'd0, a} - {8'd0, b};
      3'd2:    return {8'd0, a} * {8'd0, b};
      default: return {8'd0, a ^ b};
    endcase
  endfunction

  always @(posedge clk) alu_result <= alu_f(alu_op_code, alu_a, alu_b);

  // Scoreboard
  logic [17:0] sb[$];

  always @(negedge clk) begin
    logic [17:0] e;
    if (rst) sb.delete();
    else begin
      if (req_ready != '0) begin
        chk("rdy_onehot", 32'($onehot(req_ready)), 32'd1);
        for (int i = 0; i < NREQ; i++)
          if (req_ready[i]) begin
            e[17:16] = 2'(i);
            e[15:0]  = alu_f(req_op[3*i +: 3], req_a[8*i +: 8], req_b[8*i +: 8]);
            sb.push_back(e);
          end
      end
      if (rsp_valid && rsp_ready) begin
        n_rsp++;
        if (sb.size() == 0) chk("unexpected_rsp", 32'd1, 32'd0);
        else begin
          e = sb.pop_front();
          chk("rsp_id", 32'(rsp_id), 32'(e[17:16]));
          chk("rsp_result", 32'(rsp_result), 32'(e[15:0]));
        end
      end
    end
  end

  // Per-cycle samples taken at the negedge
  logic [NREQ-1:0] s_rdy;
  logic            s_rv, s_busy;
  logic [1:0]      s_id;
  logic [15:0]     s_res;

  // One cycle: sample mid-cycle, then step past the edge; accepted requesters drop valid.
  task automatic cyc();
    @(negedge clk);
    s_rdy = req_ready; s_rv = rsp_valid; s_id = rsp_id; s_res = rsp_result; s_busy = busy;
    @(posedge clk); #1;
    for (int i = 0; i < NREQ; i++) if (s_rdy[i]) req_valid[i] = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    req_op[3*i +: 3] = op;
    req_a[8*i +: 8]  = a;
    req_b[8*i +: 8]  = b;
    req_valid[i]     = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic drain(input string tag);
    bit done = 0;
    for (int k = 0; k < 60; k++) begin
      cyc();
      if (req_valid == '0 && !s_busy && sb.size() == 0) begin done = 1; break; end
    end
    chk(tag, 32'(done), 32'd1);
  endtask

  task automatic wait_rdy(input string tag, input logic [NREQ-1:0] mask);
    bit hit = 0;
    for (int k = 0; k < 30; k++) begin
      cyc();
      if ((s_rdy & mask) != '0) begin hit = 1; break; end
    end
    chk(tag, 32'(hit), 32'd1);
  endtask

  task automatic wait_rsp(input string tag);
    bit hit = 0;
    for (int k = 0; k < 30; k++) begin
      cyc();
      if (s_rv) begin hit = 1; break; end
    end
    chk(tag, 32'(hit), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int gord[$];
    logic [1:0]  id0;
    logic [15:0] res0;

    rst = 1'b1; req_valid = '0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rdy", 32'(req_ready), 32'd0);
    chk("rst_alu", {13'd0, alu_op_code, alu_a, alu_b}, 32'd0);
    chk("rst_rsp", {14'd0, rsp_id, rsp_result}, 32'd0);
    rst = 1'b0;

    // Single add request, cycle-exact latency
    set_req(0, 3'd0, 8'd200, 8'd100);
    cyc(); chk("t32_rdy_c0", 32'(s_rdy), 32'd0);
    cyc(); chk("t32_rdy_c1", 32'(s_rdy), 32'b0001);
    cyc(); chk("t32_rv_c2", 32'(s_rv), 32'd0);
    cyc(); chk("t32_rv_c3", 32'(s_rv), 32'd0);
    cyc(); chk("t32_rv_c4", 32'(s_rv), 32'd1);
    chk("t32_id", 32'(s_id), 32'd0);
    chk("t32_res", 32'(s_res), 32'd300);
    drain("t32_drain");

    // All four at once from reset: round-robin order 0..3
    do_reset();
    base = n_rsp;
    for (int i = 0; i < NREQ; i++) set_req(i, 3'd2, 8'hFF, 8'hFF);
    for (int k = 0; k < 80 && n_rsp < base + 4; k++) begin
      cyc();
      for (int i = 0; i < NREQ; i++) if (s_rdy[i]) gord.push_back(i);
    end
    chk("t33_nrsp", 32'(n_rsp - base), 32'd4);
    chk("t33_ngrant", 32'(gord.size()), 32'd4);
    for (int i = 0; i < gord.size() && i < 4; i++) chk("t33_order", 32'(gord[i]), 32'(i));
    drain("t33_drain");

    // Back-pressure: response held, nothing new accepted
    rsp_ready = 1'b0;
    set_req(1, 3'd1, 8'd50, 8'd8);
    wait_rsp("t34_rsp_seen");
    set_req(2, 3'd0, 8'd5, 8'd6);
    id0 = s_id; res0 = s_res;
    chk("t34_id", 32'(id0), 32'd1);
    chk("t34_res", 32'(res0), 32'd42);
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("t34_hold_rv", 32'(s_rv), 32'd1);
      chk("t34_hold_id", 32'(s_id), 32'(id0));
      chk("t34_hold_res", 32'(s_res), 32'(res0));
      chk("t34_hold_rdy", 32'(s_rdy), 32'd0);
    end
    rsp_ready = 1'b1;
    drain("t34_drain");

    // Reset during WAIT aborts the operation
    set_req(2, 3'd0, 8'd1, 8'd2);
    wait_rdy("t35_acc", 4'b0100);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t35_busy", 32'(busy), 32'd0);
    chk("t35_rv", 32'(rsp_valid), 32'd0);
    base = n_rsp;
    repeat (8) cyc();
    chk("t35_no_rsp", 32'(n_rsp - base), 32'd0);
    set_req(3, 3'd3, 8'd77, 8'd3);
    wait_rsp("t35_rsp3_seen");
    chk("t35_id3", 32'(s_id), 32'd3);
    chk("t35_res3", 32'(s_res), 32'(16'd77 ^ 16'd3));
    drain("t35_drain");

    // Requester 1 withdraws in ISSUE: no accept, ptr and ALU drive unchanged
    base = n_rsp;
    set_req(1, 3'd0, 8'd9, 8'd9);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    #1;
    chk("t36_rdy_now", 32'(req_ready), 32'd0);
    cyc();
    chk("t36_rdy", 32'(s_rdy), 32'd0);
    chk("t36_busy", 32'(busy), 32'd0);
    chk("t36_alu", {13'd0, alu_op_code, alu_a, alu_b}, {13'd0, 3'd3, 8'd77, 8'd3});
    repeat (4) cyc();
    chk("t36_no_rsp", 32'(n_rsp - base), 32'd0);
    set_req(1, 3'd0, 8'd10, 8'd20);
    set_req(3, 3'd1, 8'd30, 8'd40);
    wait_rdy("t36_acc", 4'b1111);
    chk("t36_ptr_grant", 32'(s_rdy), 32'b0010);
    drain("t36_drain");

`ifdef ALU_ARB_STATS_EN
    do_reset();
    for (int n = 0; n < 3; n++) begin
      set_req(2, 3'd0, 8'(n), 8'd1);
      wait_rdy("t37_acc", 4'b0100);
      drain("t37_drain");
    end
    chk("t37_cnt0", 32'(grant_cnt[15:0]), 32'd0);
    chk("t37_cnt1", 32'(grant_cnt[31:16]), 32'd0);
    chk("t37_cnt2", 32'(grant_cnt[47:32]), 32'd3);
    chk("t37_cnt3", 32'(grant_cnt[63:48]), 32'd0);
`endif

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
